// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-ported data memory between the pipeline MEM
//               stage (lw/sw) and a secondary debug/DMA port. Issues one
//               mem_en strobe per access, waits MEM_LAT cycles for read data,
//               and stalls the pipeline until its load/store completes.
//               Optional macro MEM_ARB_RR_EN selects round-robin arbitration
//               instead of fixed priority with the MAX_WAIT starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  // pipeline MEM stage
  input  logic        p_valid,
  input  logic [31:0] p_instruction,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_stall,
  output logic        p_done,
  output logic [31:0] p_rdata,
  // secondary port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  // memory
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [3:0] c_lat_end = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_lat_cnt;
  logic        r_owner_d;
  logic        r_is_write;

  logic [5:0]  w_opcode;
  logic        w_p_is_sw;
  logic        w_preq;
  logic        w_any_req;
  logic        w_d_wins;
  logic        w_unused_instr;

  assign w_opcode       = p_instruction[31:26];
  assign w_p_is_sw      = (w_opcode == c_op_sw);
  assign w_preq         = p_valid && ((w_opcode == c_op_lw) || w_p_is_sw);
  assign w_any_req      = w_preq || d_req;
  assign w_unused_instr = ^p_instruction[25:0];

  // Pipeline is held until its own completion pulse, so it advances with p_rdata
  assign p_stall = w_preq && !p_done;

`ifdef MEM_ARB_RR_EN
  // 0: pipeline has priority on the next contested grant, 1: secondary does
  logic r_rr_ptr;

  assign w_d_wins = d_req && (!w_preq || r_rr_ptr);

  // Flip priority only when both requesters competed in an IDLE cycle
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rr_ptr <= 1'b0;
    end else if (r_state == S_IDLE && w_preq && d_req) begin
      r_rr_ptr <= !w_d_wins;
    end
  end
`else
  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);
  logic [3:0] r_wait_cnt;

  assign w_d_wins = d_req && (!w_preq || (r_wait_cnt >= c_max_wait));

  // Count lost arbitrations of a pending secondary request; cleared on grant
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == S_IDLE && d_req) begin
      if (w_d_wins) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != 4'hF) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: issue from IDLE, wait out the latency in BUSY, one DONE cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_BUSY;
      S_BUSY:  if (r_lat_cnt == c_lat_end) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Memory strobes, latency counter, response capture and completion pulses
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      p_done     <= 1'b0;
      p_rdata    <= 32'd0;
      d_gnt      <= 1'b0;
      d_done     <= 1'b0;
      d_rdata    <= 32'd0;
      r_lat_cnt  <= 4'd0;
      r_owner_d  <= 1'b0;
      r_is_write <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      d_gnt  <= 1'b0;
      p_done <= 1'b0;
      d_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            mem_en    <= 1'b1;
            r_owner_d <= w_d_wins;
            d_gnt     <= w_d_wins;
            r_lat_cnt <= 4'd0;
            if (w_d_wins) begin
              mem_we     <= d_we;
              r_is_write <= d_we;
              mem_addr   <= d_addr;
              mem_wdata  <= d_wdata;
            end else begin
              mem_we     <= w_p_is_sw;
              r_is_write <= w_p_is_sw;
              mem_addr   <= p_addr;
              mem_wdata  <= p_wdata;
            end
          end
        end
        S_BUSY: begin
          if (r_lat_cnt == c_lat_end) begin
            // Stores leave the owner's read-data register untouched
            if (!r_is_write) begin
              if (r_owner_d) d_rdata <= mem_rdata;
              else           p_rdata <= mem_rdata;
            end
            p_done <= !r_owner_d;
            d_done <= r_owner_d;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: per-cycle vector
//               table plus reset, starvation / round-robin sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] LW = 32'h8C00_0000;
  localparam logic [31:0] SW = 32'hAC00_0000;
  localparam logic [31:0] RT = 32'h012A_4020;

  logic        clk;
  logic        rst_n;
  logic        p_valid;
  logic [31:0] p_instruction, p_addr, p_wdata;
  logic        p_stall, p_done;
  logic [31:0] p_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MEM_LAT(LAT), .MAX_WAIT(4)) dut (
    .CLOCK(clk), .RESET_N(rst_n),
    .p_valid(p_valid), .p_instruction(p_instruction), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_stall(p_stall), .p_done(p_done), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data appears LAT cycles after the mem_en cycle only
  logic [31:0] rd_pipe [LAT];
  logic        rd_vld  [LAT];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10)      return 32'hDEAD_BEEF;
    else if (a == 32'h40) return 32'hCAFE_F00D;
    else                  return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        rd_vld[i]  <= 1'b0;
        rd_pipe[i] <= 32'd0;
      end
    end else begin
      rd_vld[0]  <= mem_en && !mem_we;
      rd_pipe[0] <= mem_word(mem_addr);
      for (int i = 1; i < LAT; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign mem_rdata = rd_vld[LAT-1] ? rd_pipe[LAT-1] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] instr, paddr, pwdata;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic        e_stall, e_pdone;
    logic [31:0] e_prdata;
    logic        e_men, e_mwe;
    logic [31:0] e_maddr, e_mwdata;
    logic        e_dgnt, e_ddone;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs [24];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int lat;
    bit seen;
    bit gq [$];
    bit exp_order [6];
    int dd_seen;
    bit granted;

    //        pv  instr  paddr     pwdata         dreq dwe daddr    dwdata          stall pdone prdata        men mwe maddr     mwdata         dgnt ddone drdata
    vecs[0]  = '{1, LW, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,          1, 0, 32'h0,          0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[1]  = '{1, LW, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,          1, 0, 32'h0,          1, 0, 32'h10, 32'h0,          0, 0, 32'h0};
    vecs[2]  = '{1, LW, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,          1, 0, 32'h0,          0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[3]  = '{1, LW, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,          1, 0, 32'h0,          0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[4]  = '{1, LW, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,          0, 1, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[5]  = '{1, SW, 32'h20, 32'h12345678, 0, 0, 32'h0,  32'h0,          1, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[6]  = '{1, SW, 32'h20, 32'h12345678, 0, 0, 32'h0,  32'h0,          1, 0, 32'hDEADBEEF,   1, 1, 32'h20, 32'h12345678,   0, 0, 32'h0};
    vecs[7]  = '{1, SW, 32'h20, 32'h12345678, 0, 0, 32'h0,  32'h0,          1, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[8]  = '{1, SW, 32'h20, 32'h12345678, 0, 0, 32'h0,  32'h0,          1, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[9]  = '{1, SW, 32'h20, 32'h12345678, 0, 0, 32'h0,  32'h0,          0, 1, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[10] = '{1, RT, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,          0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[11] = '{1, RT, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,          0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[12] = '{0, 32'h0, 32'h0, 32'h0,      1, 1, 32'h80, 32'h55AA55AA,   0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[13] = '{0, 32'h0, 32'h0, 32'h0,      1, 1, 32'h80, 32'h55AA55AA,   0, 0, 32'hDEADBEEF,   1, 1, 32'h80, 32'h55AA55AA,   1, 0, 32'h0};
    vecs[14] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[15] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[16] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 1, 32'h0};
    vecs[17] = '{1, LW, 32'h44, 32'h0,        1, 0, 32'h40, 32'h0,          1, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[18] = '{1, LW, 32'h44, 32'h0,        0, 0, 32'h40, 32'h0,          1, 0, 32'hDEADBEEF,   1, 0, 32'h44, 32'h0,          0, 0, 32'h0};
    vecs[19] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[20] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 0, 32'hDEADBEEF,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[21] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 1, 32'hA5A50044,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[22] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 0, 32'hA5A50044,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};
    vecs[23] = '{0, 32'h0, 32'h0, 32'h0,      0, 0, 32'h0,  32'h0,          0, 0, 32'hA5A50044,   0, 0, 32'h0,  32'h0,          0, 0, 32'h0};

    // ---------------- reset state ----------------
    rst_n = 1'b1;
    p_valid = 1'b0; p_instruction = 32'h0; p_addr = 32'h0; p_wdata = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_en", mem_en, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset p_done", p_done, 0);
    chk("reset p_rdata", p_rdata, 0);
    chk("reset d_gnt", d_gnt, 0);
    chk("reset d_done", d_done, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset p_stall", p_stall, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < 24; i++) begin
      p_valid = vecs[i].pv; p_instruction = vecs[i].instr;
      p_addr = vecs[i].paddr; p_wdata = vecs[i].pwdata;
      d_req = vecs[i].dreq; d_we = vecs[i].dwe;
      d_addr = vecs[i].daddr; d_wdata = vecs[i].dwdata;
      @(negedge clk);
      chk($sformatf("v%0d p_stall", i), p_stall, vecs[i].e_stall);
      chk($sformatf("v%0d p_done", i), p_done, vecs[i].e_pdone);
      chk($sformatf("v%0d p_rdata", i), p_rdata, vecs[i].e_prdata);
      chk($sformatf("v%0d mem_en", i), mem_en, vecs[i].e_men);
      chk($sformatf("v%0d d_gnt", i), d_gnt, vecs[i].e_dgnt);
      chk($sformatf("v%0d d_done", i), d_done, vecs[i].e_ddone);
      chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_drdata);
      if (vecs[i].e_men) begin
        chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_mwe);
        chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
        if (vecs[i].e_mwe)
          chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      end
      @(posedge clk); #1;
    end

    // ---------------- reset during BUSY ----------------
    p_valid = 1'b1; p_instruction = LW; p_addr = 32'h10;
    @(posedge clk); #3;
    chk("rst pre mem_en", mem_en, 1);
    rst_n = 1'b0; #1;
    chk("rst async mem_en", mem_en, 0);
    chk("rst async mem_addr", mem_addr, 0);
    chk("rst async p_rdata", p_rdata, 0);
    chk("rst async p_done", p_done, 0);
    p_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (p_done || mem_en || d_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst no stale done", seen, 0);
    p_valid = 1'b1; p_instruction = LW; p_addr = 32'h10;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (p_done) break;
      lat++;
      if (c < 19) begin
        @(posedge clk); #1;
      end
    end
    chk("rst relaunch latency", lat, 2 + LAT);
    chk("rst relaunch p_rdata", p_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    p_valid = 1'b0;
    @(posedge clk); #1;

`ifdef MEM_ARB_RR_EN
    // ---------------- round robin, both continuous ----------------
    exp_order = '{0, 1, 0, 1, 0, 1};
    p_valid = 1'b1; p_instruction = LW; p_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 0; c < 80 && gq.size() < 6; c++) begin
      @(negedge clk);
      if (mem_en) gq.push_back(d_gnt);
      @(posedge clk); #1;
    end
    chk("rr grant count", gq.size(), 6);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk($sformatf("rr grant %0d d_gnt", k), gq[k], exp_order[k]);
    p_valid = 1'b0; d_req = 1'b0;
`else
    // ---------------- starvation guard ----------------
    exp_order = '{0, 0, 0, 0, 1, 0};
    dd_seen = 0;
    granted = 1'b0;
    p_valid = 1'b1; p_instruction = LW; p_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 0; c < 80 && gq.size() < 6; c++) begin
      @(negedge clk);
      if (mem_en) begin
        gq.push_back(d_gnt);
        if (d_gnt) begin
          granted = 1'b1;
          chk("starve d mem_addr", mem_addr, 32'h40);
        end
      end
      if (d_done) begin
        dd_seen++;
        chk("starve d_rdata", d_rdata, 32'hCAFEF00D);
      end
      @(posedge clk); #1;
      if (granted) d_req = 1'b0;
    end
    chk("starve grant count", gq.size(), 6);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk($sformatf("starve grant %0d d_gnt", k), gq[k], exp_order[k]);
    chk("starve d_done count", dd_seen, 1);
    p_valid = 1'b0; d_req = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
